// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle between the generator and its consumers.
// frame_cnt exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
    parameter int CNT_W   = 11,
    parameter int FRAME_W = 16
);
    logic               en;
    logic [CNT_W-1:0]   hcount;
    logic [CNT_W-1:0]   vcount;
    logic               hsync;
    logic               vsync;
    logic               hblnk;
    logic               vblnk;
    logic               de;
    logic               line_start;
    logic               frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FRAME_W-1:0] frame_cnt;
`endif

    modport master (
        input  en,
        output hcount, vcount, hsync, vsync, hblnk, vblnk, de,
`ifdef VGA_TIMING_FRAME_CNT_EN
        output frame_cnt,
`endif
        output line_start, frame_start
    );

    modport slave (
        output en,
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, de,
`ifdef VGA_TIMING_FRAME_CNT_EN
        input  frame_cnt,
`endif
        input  line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster counters, sync, blanking and strobes.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 1024,
    parameter int H_FP      = 24,
    parameter int H_SYNC    = 136,
    parameter int H_BP      = 160,
    parameter int V_ACTIVE  = 768,
    parameter int V_FP      = 3,
    parameter int V_SYNC    = 6,
    parameter int V_BP      = 29,
    parameter bit HSYNC_ACT = 1'b1,
    parameter bit VSYNC_ACT = 1'b1,
    parameter int CNT_W     = 11,
    parameter int FRAME_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vga_timing_gen_if.master      vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;

    // Extra bit so the sync stop bound can equal 2^CNT_W without truncating.
    localparam logic [CNT_W:0]   H_ACT_C = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0]   HS_B_C  = (CNT_W+1)'(HS_BEG);
    localparam logic [CNT_W:0]   HS_E_C  = (CNT_W+1)'(HS_END);
    localparam logic [CNT_W:0]   V_ACT_C = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0]   VS_B_C  = (CNT_W+1)'(VS_BEG);
    localparam logic [CNT_W:0]   VS_E_C  = (CNT_W+1)'(VS_END);
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        CNT_W < 1 || CNT_W > 30 ||
        (64'd1 << CNT_W) < 64'(H_TOTAL) ||
        (64'd1 << CNT_W) < 64'(V_TOTAL)) begin : g_bad_cfg
        $fatal(1, "vga_timing_gen: illegal timing parameters");
    end

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             hblnk_q, hblnk_d;
    logic             vblnk_q, vblnk_d;
    logic             de_q, de_d;
    logic             line_q, line_d;
    logic             frame_q, frame_d;
    logic [CNT_W:0]   hx;
    logic [CNT_W:0]   vx;

    // Next raster position, and all level outputs decoded from it so they
    // land in the same register stage as the counters themselves.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        line_d   = 1'b0;
        frame_d  = 1'b0;
        if (vif.en) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                line_d   = 1'b1;
                if (vcount_q == V_LAST) begin
                    vcount_d = '0;
                    frame_d  = 1'b1;
                end else begin
                    vcount_d = vcount_q + 1'b1;
                end
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
        hx      = {1'b0, hcount_d};
        vx      = {1'b0, vcount_d};
        hblnk_d = (hx >= H_ACT_C);
        vblnk_d = (vx >= V_ACT_C);
        de_d    = !hblnk_d && !vblnk_d;
        hsync_d = (hx >= HS_B_C && hx < HS_E_C) ? HSYNC_ACT : !HSYNC_ACT;
        vsync_d = (vx >= VS_B_C && vx < VS_E_C) ? VSYNC_ACT : !VSYNC_ACT;
    end

    // Raster state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hsync_q  <= !HSYNC_ACT;
            vsync_q  <= !VSYNC_ACT;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            de_q     <= 1'b1;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblnk_q  <= hblnk_d;
            vblnk_q  <= vblnk_d;
            de_q     <= de_d;
            line_q   <= line_d;
            frame_q  <= frame_d;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FRAME_W-1:0] fcnt_q, fcnt_d;

    // Completed-frame count, bumped alongside the frame_start strobe.
    always_comb begin
        fcnt_d = fcnt_q;
        if (frame_d) fcnt_d = fcnt_q + 1'b1;
    end

    // Frame counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fcnt_q <= '0;
        else        fcnt_q <= fcnt_d;
    end

    assign vif.frame_cnt = fcnt_q;
`endif

    assign vif.hcount      = hcount_q;
    assign vif.vcount      = vcount_q;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.hblnk       = hblnk_q;
    assign vif.vblnk       = vblnk_q;
    assign vif.de          = de_q;
    assign vif.line_start  = line_q;
    assign vif.frame_start = frame_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized checks of three timing modes against a
// position-index reference model (raster position = enabled-cycle count).
module tb_vga_timing_gen;
    logic clk;
    logic rst_d, rst_s, rst_m;
    int   checks;
    int   errors;

    // Per-mode timing: 0 = default 1024x768, 1 = small (active-low sync),
    // 2 = medium (active-high sync).
    int HA [3] = '{1024, 4, 10};
    int HF [3] = '{24, 1, 2};
    int HS [3] = '{136, 2, 3};
    int HB [3] = '{160, 1, 4};
    int VA [3] = '{768, 2, 6};
    int VF [3] = '{3, 1, 2};
    int VS [3] = '{6, 1, 3};
    int VB [3] = '{29, 1, 2};
    bit HP [3] = '{1'b1, 1'b0, 1'b1};
    bit VP [3] = '{1'b1, 1'b0, 1'b1};

    // Model state: enabled-cycle count since reset and last-edge enable.
    longint nd, ns, nm;
    bit     sd, ss, sm;

    vga_timing_gen_if #(.CNT_W(11), .FRAME_W(16)) d_if();
    vga_timing_gen_if #(.CNT_W(11), .FRAME_W(2))  s_if();
    vga_timing_gen_if #(.CNT_W(11), .FRAME_W(16)) m_if();

    vga_timing_gen u_d (.clk(clk), .rst_n(rst_d), .vif(d_if));

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_ACT(1'b0), .VSYNC_ACT(1'b0), .CNT_W(11), .FRAME_W(2)
    ) u_s (.clk(clk), .rst_n(rst_s), .vif(s_if));

    vga_timing_gen #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(3), .V_BP(2),
        .HSYNC_ACT(1'b1), .VSYNC_ACT(1'b1), .CNT_W(11), .FRAME_W(16)
    ) u_m (.clk(clk), .rst_n(rst_m), .vif(m_if));

    wire [28:0] act_d = {d_if.hcount, d_if.vcount, d_if.hsync, d_if.vsync,
                         d_if.hblnk, d_if.vblnk, d_if.de,
                         d_if.line_start, d_if.frame_start};
    wire [28:0] act_s = {s_if.hcount, s_if.vcount, s_if.hsync, s_if.vsync,
                         s_if.hblnk, s_if.vblnk, s_if.de,
                         s_if.line_start, s_if.frame_start};
    wire [28:0] act_m = {m_if.hcount, m_if.vcount, m_if.hsync, m_if.vsync,
                         m_if.hblnk, m_if.vblnk, m_if.de,
                         m_if.line_start, m_if.frame_start};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for mode m after n enabled cycles; stb = last edge enabled.
    function automatic logic [28:0] exp_vec(int m, longint n, bit stb);
        longint ht, vt, h, v;
        logic [10:0] h11, v11;
        bit hs, vs, hb, vb, ls, fs;
        ht  = longint'(HA[m] + HF[m] + HS[m] + HB[m]);
        vt  = longint'(VA[m] + VF[m] + VS[m] + VB[m]);
        h   = n % ht;
        v   = (n / ht) % vt;
        hb  = h >= HA[m];
        vb  = v >= VA[m];
        hs  = (h >= HA[m] + HF[m] && h < HA[m] + HF[m] + HS[m]) ? HP[m] : !HP[m];
        vs  = (v >= VA[m] + VF[m] && v < VA[m] + VF[m] + VS[m]) ? VP[m] : !VP[m];
        ls  = stb && (h == 0);
        fs  = ls && (v == 0);
        h11 = h[10:0];
        v11 = v[10:0];
        return {h11, v11, hs, vs, hb, vb, !hb && !vb, ls, fs};
    endfunction

    function automatic longint exp_frames(int m, longint n);
        longint ft;
        ft = longint'((HA[m] + HF[m] + HS[m] + HB[m]) *
                      (VA[m] + VF[m] + VS[m] + VB[m]));
        return n / ft;
    endfunction

    // One clock: drive enables at the falling edge, sample 1 after rising.
    task automatic cycle(bit ed, bit es, bit em);
        @(negedge clk);
        d_if.en = ed;
        s_if.en = es;
        m_if.en = em;
        @(posedge clk);
        #1;
        if (rst_d) begin nd += ed ? 1 : 0; sd = ed; end
        if (rst_s) begin ns += es ? 1 : 0; ss = es; end
        if (rst_m) begin nm += em ? 1 : 0; sm = em; end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_d = 1'b0; rst_s = 1'b0; rst_m = 1'b0;
        d_if.en = 1'b1; s_if.en = 1'b1; m_if.en = 1'b1;
        nd = 0; ns = 0; nm = 0; sd = 0; ss = 0; sm = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (act_d !== exp_vec(0, 0, 1'b0)) begin
            errors++;
            $display("FAIL reset_default: got %h expected %h", act_d, exp_vec(0, 0, 1'b0));
        end
        checks++;
        if (act_s !== exp_vec(1, 0, 1'b0)) begin
            errors++;
            $display("FAIL reset_small: got %h expected %h", act_s, exp_vec(1, 0, 1'b0));
        end
        checks++;
        if (act_m !== exp_vec(2, 0, 1'b0)) begin
            errors++;
            $display("FAIL reset_medium: got %h expected %h", act_m, exp_vec(2, 0, 1'b0));
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        checks++;
        if (d_if.frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_frame_cnt: got %0d expected 0", d_if.frame_cnt);
        end
`endif
        @(negedge clk);
        rst_d = 1'b1; rst_s = 1'b1; rst_m = 1'b1;
        d_if.en = 1'b0; s_if.en = 1'b0; m_if.en = 1'b0;
        cycle(1'b1, 1'b1, 1'b1);
        checks++;
        if (d_if.hcount !== 11'd1 || d_if.vcount !== 11'd0 || d_if.line_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_step: got h=%0d v=%0d ls=%b expected h=1 v=0 ls=0",
                     d_if.hcount, d_if.vcount, d_if.line_start);
        end
        checks++;
        if (act_s !== exp_vec(1, ns, ss)) begin
            errors++;
            $display("FAIL reset_first_step_small: got %h expected %h", act_s, exp_vec(1, ns, ss));
        end
    endtask

    task automatic test_default_line();
        int n_hs, n_hb, n_ls, bad;
        n_hs = 0; n_hb = 0; n_ls = 0; bad = 0;
        for (int i = 0; i < 1344; i++) begin
            cycle(1'b1, 1'b1, 1'b1);
            if (d_if.hsync === 1'b1) n_hs++;
            if (d_if.hblnk === 1'b1) n_hb++;
            if (d_if.line_start === 1'b1) begin
                n_ls++;
                if (d_if.vcount !== 11'd1) bad++;
            end
            checks++;
            if (act_d !== exp_vec(0, nd, sd)) begin
                errors++;
                $display("FAIL default_line step %0d: got %h expected %h",
                         i, act_d, exp_vec(0, nd, sd));
            end
        end
        checks++;
        if (n_hs != 136) begin
            errors++;
            $display("FAIL default_hsync_len: got %0d expected 136", n_hs);
        end
        checks++;
        if (n_hb != 320) begin
            errors++;
            $display("FAIL default_hblnk_len: got %0d expected 320", n_hb);
        end
        checks++;
        if (n_ls != 1 || bad != 0) begin
            errors++;
            $display("FAIL default_line_start: got count=%0d badv=%0d expected 1/0", n_ls, bad);
        end
    endtask

    task automatic test_enable_gating();
        int n_en, n_ls;
        bit e0, e1, e2;
        n_en = 0; n_ls = 0;
        while (n_en < 1344) begin
            e0 = ($urandom_range(0, 2) != 0);
            e1 = $urandom_range(0, 1) == 1;
            e2 = $urandom_range(0, 1) == 1;
            cycle(e0, e1, e2);
            if (e0) n_en++;
            if (d_if.line_start === 1'b1) n_ls++;
            checks++;
            if (act_d !== exp_vec(0, nd, sd)) begin
                errors++;
                $display("FAIL gating_default n=%0d: got %h expected %h",
                         nd, act_d, exp_vec(0, nd, sd));
            end
            checks++;
            if (act_s !== exp_vec(1, ns, ss)) begin
                errors++;
                $display("FAIL gating_small n=%0d: got %h expected %h",
                         ns, act_s, exp_vec(1, ns, ss));
            end
        end
        checks++;
        if (n_ls != 1) begin
            errors++;
            $display("FAIL gating_line_count: got %0d expected 1", n_ls);
        end
    endtask

    task automatic test_medium_frames();
        int n_vs;
        n_vs = 0;
        for (int i = 0; i < 1600; i++) begin
            cycle(1'b0, 1'b0, $urandom_range(0, 3) != 0);
            checks++;
            if (act_m !== exp_vec(2, nm, sm)) begin
                errors++;
                $display("FAIL medium n=%0d: got %h expected %h",
                         nm, act_m, exp_vec(2, nm, sm));
            end
            if (m_if.frame_start === 1'b1) n_vs++;
`ifdef VGA_TIMING_FRAME_CNT_EN
            checks++;
            if (longint'(m_if.frame_cnt) != exp_frames(2, nm) % 65536) begin
                errors++;
                $display("FAIL medium_frame_cnt: got %0d expected %0d",
                         m_if.frame_cnt, exp_frames(2, nm) % 65536);
            end
`endif
        end
        checks++;
        if (n_vs < 2) begin
            errors++;
            $display("FAIL medium_frame_starts: got %0d expected at least 2", n_vs);
        end
    endtask

    task automatic test_frame_cnt();
        int fseq[$];
        int want[5] = '{1, 2, 3, 0, 1};
        @(negedge clk);
        rst_s = 1'b0;
        s_if.en = 1'b0;
        @(negedge clk);
        rst_s = 1'b1;
        ns = 0; ss = 0;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b0, 1'b1, 1'b0);
            checks++;
            if (act_s !== exp_vec(1, ns, ss)) begin
                errors++;
                $display("FAIL small_frames n=%0d: got %h expected %h",
                         ns, act_s, exp_vec(1, ns, ss));
            end
`ifdef VGA_TIMING_FRAME_CNT_EN
            if (s_if.frame_start === 1'b1) fseq.push_back(int'(s_if.frame_cnt));
`else
            if (s_if.frame_start === 1'b1) fseq.push_back(int'(exp_frames(1, ns) % 4));
`endif
        end
        checks++;
        if (fseq.size() != 5) begin
            errors++;
            $display("FAIL small_frame_count: got %0d expected 5", fseq.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (fseq[k] != want[k]) begin
                    errors++;
                    $display("FAIL frame_cnt_seq[%0d]: got %0d expected %0d",
                             k, fseq[k], want[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        repeat (17) cycle(1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst_s = 1'b0;
        #1;
        ns = 0; ss = 0;
        checks++;
        if (act_s !== exp_vec(1, 0, 1'b0)) begin
            errors++;
            $display("FAIL mid_reset_immediate: got %h expected %h", act_s, exp_vec(1, 0, 1'b0));
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        checks++;
        if (s_if.frame_cnt !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset_frame_cnt: got %0d expected 0", s_if.frame_cnt);
        end
`endif
        @(posedge clk);
        #1;
        checks++;
        if (act_s !== exp_vec(1, 0, 1'b0)) begin
            errors++;
            $display("FAIL mid_reset_hold: got %h expected %h", act_s, exp_vec(1, 0, 1'b0));
        end
        @(negedge clk);
        rst_s = 1'b1;
        s_if.en = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cycle(1'b0, $urandom_range(0, 1) == 1, 1'b0);
            checks++;
            if (act_s !== exp_vec(1, ns, ss)) begin
                errors++;
                $display("FAIL post_reset_small n=%0d: got %h expected %h",
                         ns, act_s, exp_vec(1, ns, ss));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_d = 1'b1; rst_s = 1'b1; rst_m = 1'b1;
        d_if.en = 1'b0; s_if.en = 1'b0; m_if.en = 1'b0;
        nd = 0; ns = 0; nm = 0; sd = 0; ss = 0; sm = 0;
        test_reset();
        test_default_line();
        test_enable_gating();
        test_medium_frames();
        test_frame_cnt();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator producing horizontal/vertical counters, sync, blanking and frame/line markers for any mode described by front-porch/sync/back-porch parameters. Defaults reproduce the 1024x768 @ 60 Hz, 65 MHz timing (1344 x 806 total). It sits at the head of the video pipeline and feeds `draw_bg`, terrain and player overlays, which consume `hcount`/`vcount`/`hblnk`/`vblnk`. Adds a pixel-advance enable, programmable sync polarity and one-cycle frame/line strobes.

## Interface
Parameters:
- `H_ACTIVE`, 1024, visible pixels per line
- `H_FP`, 24, horizontal front porch (pixels)
- `H_SYNC`, 136, hsync width (pixels)
- `H_BP`, 160, horizontal back porch (pixels)
- `V_ACTIVE`, 768, visible lines
- `V_FP`, 3, vertical front porch (lines)
- `V_SYNC`, 6, vsync width (lines)
- `V_BP`, 29, vertical back porch (lines)
- `HSYNC_ACT`, 1, hsync asserted level (1 = active-high)
- `VSYNC_ACT`, 1, vsync asserted level
- `CNT_W`, 11, counter width; must hold H_TOTAL-1 and V_TOTAL-1
- `FRAME_W`, 16, frame counter width (used only with macro)

Ports:
- `clk` in 1: pixel clock
- `rst_n` in 1: asynchronous, active-low reset
- `en` in 1: advance raster by one pixel this cycle
- `hcount` out CNT_W: current pixel column
- `vcount` out CNT_W: current line
- `hsync` out 1: horizontal sync, level per HSYNC_ACT
- `vsync` out 1: vertical sync, level per VSYNC_ACT
- `hblnk` out 1: horizontal blanking
- `vblnk` out 1: vertical blanking
- `de` out 1: display enable = !hblnk && !vblnk
- `line_start` out 1: one-cycle strobe, hcount just wrapped to 0
- `frame_start` out 1: one-cycle strobe, (hcount,vcount) just wrapped to (0,0)
- `frame_cnt` out FRAME_W: frames completed (only with VGA_TIMING_FRAME_CNT_EN)

## Operation
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; HSYNC_START = H_ACTIVE+H_FP; HSYNC_STOP = HSYNC_START+H_SYNC; vertical likewise.
- Elaboration check: every timing parameter ≥ 1; 2^CNT_W ≥ max(H_TOTAL, V_TOTAL); violation is a fatal elaboration error.
- On `en`=1: hcount increments; at H_TOTAL-1 wraps to 0 and vcount increments; vcount at V_TOTAL-1 with hcount wrap returns to 0.
- On `en`=0: counters and all level outputs hold; strobes drop to 0.
- All outputs are registered and mutually aligned: in any cycle, hsync/hblnk/vsync/vblnk/de reflect the hcount/vcount shown in that same cycle.
  - hblnk = hcount ≥ H_ACTIVE; vblnk = vcount ≥ V_ACTIVE.
  - hsync asserted iff HSYNC_START ≤ hcount < HSYNC_STOP; vsync iff VSYNC_START ≤ vcount < VSYNC_STOP (vertical sync changes on line boundaries only).
- line_start high exactly in the cycle hcount becomes 0 through an enabled wrap; frame_start additionally requires vcount becoming 0. Neither asserts on reset exit.

## Timing
- Reset (async assert, sync release): hcount=0, vcount=0, hblnk=0, vblnk=0, de=1, hsync=!HSYNC_ACT, vsync=!VSYNC_ACT, line_start=0, frame_start=0, frame_cnt=0.
- First enabled clock after release shows hcount=1.
- Latency: counter advance and all derived outputs change on the same rising edge following an `en`=1 sample (1 cycle).
- Defaults: hsync asserted hcount 1048..1183; hblnk 1024..1343; vsync lines 771..776; vblnk 768..805; one frame = 1344*806 = 1 083 264 enabled cycles.
- Reset mid-frame: immediate return to reset values regardless of `en`; no strobe emitted.
- `en` held low across a wrap point: wrap and strobe occur on the first enabled cycle, never duplicated.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined: `frame_cnt` port present; increments by 1 in the cycle frame_start asserts, wraps modulo 2^FRAME_W.
- Undefined: `frame_cnt` port and counter absent; all other behaviour identical.

## Test plan
- Reset: hold rst_n=0 with en=1 -> all outputs at reset values listed; release, one clock -> hcount=1, vcount=0, line_start=0.
- Default line: en=1 for 1344 cycles -> hsync asserted exactly 136 cycles starting hcount=1048, hblnk 320 cycles, line_start once with vcount=1.
- Frame wrap: run to hcount=1343, vcount=805, one clock -> (0,0), frame_start=1 for one cycle, vsync high on lines 771..776 only.
- Small mode H=4/1/2/1, V=2/1/1/1, HSYNC_ACT=0, VSYNC_ACT=0 -> H_TOTAL=8, V_TOTAL=5, hsync low at hcount 5..6, vsync low at vcount 3.
- Enable gating: toggle en 1/0 pseudo-randomly -> counters advance only on en=1, strobes never exceed one cycle, line count still 1344 enabled cycles.
- Macro on, FRAME_W=2, small mode: run 5 frames -> frame_cnt sequence 1,2,3,0,1; assert rst_n mid-frame -> frame_cnt=0 immediately.
